// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: opcodes, control words,
// and the bit positions of the EX / M / WB fields inside a control word.
package pipe_ctrl_pkg;

    localparam int CTRL_W = 9;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // Opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_NOP   = 6'b100000;

    // Control words: RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg
    localparam ctrl_word_t CW_RTYPE = 9'b110000010;
    localparam ctrl_word_t CW_LW    = 9'b000101011;
    localparam ctrl_word_t CW_SW    = 9'b000100100;
    localparam ctrl_word_t CW_BEQ   = 9'b001010000;
    localparam ctrl_word_t CW_ADDI  = 9'b000100010;
    localparam ctrl_word_t CW_NOP   = 9'b000000000;

    // Field slices
    localparam int EX_HI       = 8;
    localparam int EX_LO       = 5;
    localparam int M_HI        = 4;
    localparam int M_LO        = 2;
    localparam int WB_HI       = 1;
    localparam int WB_LO       = 0;
    localparam int MEMREAD_BIT = 3;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Purely combinational opcode decoder producing the 9-bit control word and
// an illegal-opcode flag. Unknown opcodes decode to an all-zero word.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int EN_ADDI = 1
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_word_t      ctrl_word,
    output logic            illegal
);

    // Table lookup; defaults make every unlisted opcode a zero word marked illegal
    always_comb begin
        ctrl_word = CW_NOP;
        illegal   = 1'b1;
        case (opcode)
            OP_W'(OP_RTYPE): begin ctrl_word = CW_RTYPE; illegal = 1'b0; end
            OP_W'(OP_LW):    begin ctrl_word = CW_LW;    illegal = 1'b0; end
            OP_W'(OP_SW):    begin ctrl_word = CW_SW;    illegal = 1'b0; end
            OP_W'(OP_BEQ):   begin ctrl_word = CW_BEQ;   illegal = 1'b0; end
            OP_W'(OP_NOP):   begin ctrl_word = CW_NOP;   illegal = 1'b0; end
            OP_W'(OP_ADDI): begin
                if (EN_ADDI != 0) begin
                    ctrl_word = CW_ADDI;
                    illegal   = 1'b0;
                end
            end
            default: begin
                ctrl_word = CW_NOP;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage MIPS core: decodes the ID opcode, carries
// the control word through ID/EX, EX/MEM and MEM/WB, inserts a bubble on a
// load-use hazard, flushes on a taken branch and counts stalls/flushes.
// A flush overrides a simultaneous hazard: the stalled instruction is being
// discarded anyway, so the PC and IF/ID keep moving.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16,
    parameter int EN_ADDI = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             mem_branch_taken,
    input  logic             cnt_clr,
    output logic [3:0]       ex_ctrl,
    output logic [2:0]       mem_ctrl,
    output logic [1:0]       wb_ctrl,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_word_t        dec_word;
    logic              dec_illegal;
    ctrl_word_t        id_ex_word;
    logic [REG_W-1:0]  id_ex_rt;
    logic [M_HI:WB_LO] ex_mem_word;
    logic [WB_HI:WB_LO] mem_wb_word;
    logic              id_ex_memread;
    logic              hazard;
    logic              flush;
    logic              stall;

    ctrl_decode #(
        .OP_W    (OP_W),
        .EN_ADDI (EN_ADDI)
    ) u_decode (
        .opcode    (id_opcode),
        .ctrl_word (dec_word),
        .illegal   (dec_illegal)
    );

    // Load-use detection and the resulting PC / IF/ID enables
    always_comb begin
        id_ex_memread = id_ex_word[MEMREAD_BIT];
        hazard        = id_ex_memread && (id_ex_rt != '0) &&
                        ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));
        flush         = mem_branch_taken;
        stall         = hazard && !flush;
        pc_write      = !stall;
        if_id_write   = !stall;
        if_id_flush   = flush;
    end

    // ID/EX stage: zero control on bubble or flush, otherwise the decoded word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_word <= '0;
            id_ex_rt   <= '0;
            illegal_op <= 1'b0;
        end else begin
            id_ex_rt <= id_rt;
            if (flush || hazard) begin
                id_ex_word <= '0;
                illegal_op <= 1'b0;
            end else begin
                id_ex_word <= dec_word;
                illegal_op <= dec_illegal;
            end
        end
    end

    // EX/MEM and MEM/WB stages; on flush MEM/WB still retires the branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_word <= '0;
            mem_wb_word <= '0;
        end else begin
            mem_wb_word <= ex_mem_word[WB_HI:WB_LO];
            if (flush) begin
                ex_mem_word <= '0;
            end else begin
                ex_mem_word <= id_ex_word[M_HI:WB_LO];
            end
        end
    end

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (cnt_clr) begin
                flush_cnt <= '0;
            end else if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Stage field taps
    always_comb begin
        ex_ctrl  = id_ex_word[EX_HI:EX_LO];
        mem_ctrl = ex_mem_word[M_HI:M_LO];
        wb_ctrl  = mem_wb_word;
    end

endmodule
